// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 5x5 convolution engine.
package conv_pkg;

  // Kernel geometry and coefficient address map.
  localparam int KX        = 5;
  localparam int KY        = 5;
  localparam int KN        = KX * KY;
  localparam int BIAS_ADDR = KN;

  // Default datapath widths.
  localparam int PIX_BW    = 8;
  localparam int WGT_BW    = 8;
  localparam int BIAS_BW   = 16;
  localparam int PROD_BW   = PIX_BW + WGT_BW + 1;
  localparam int ACC_W     = 24;
  localparam int PART_BW   = ACC_W;
  localparam int OUT_SHIFT = 6;

  // ReLU, arithmetic shift, then clamp to [0, 2^out_bw-1].
  // The accumulator is passed sign-extended to 32 bits so any ACC_BW <= 32 works.
  function automatic logic [31:0] sat_relu(input logic signed [31:0] acc,
                                           input int shift,
                                           input int out_bw);
    logic signed [31:0] v;
    logic [31:0]        max_v;
    max_v = (32'd1 << out_bw) - 32'd1;
    v     = acc >>> shift;
    if (acc < 0)
      return '0;
    else if ($unsigned(v) > max_v)
      return max_v;
    else
      return $unsigned(v);
  endfunction

endpackage

// File: rtl/mac_row5.sv
// One kernel row: registered products (S1) and registered row sum (S2).
module mac_row5 import conv_pkg::*; #(
  parameter int I_F_BW = PIX_BW,
  parameter int W_BW   = WGT_BW,
  parameter int ACC_BW = ACC_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_en_s1,
  input  logic                     i_en_s2,
  input  logic [KX*I_F_BW-1:0]     i_pix,
  input  logic [KX*W_BW-1:0]       i_w,
  output logic signed [ACC_BW-1:0] o_row
);

  localparam int P_BW = I_F_BW + W_BW + 1;

  logic signed [P_BW-1:0]   w_prod [KX];
  logic signed [P_BW-1:0]   r_prod [KX];
  logic signed [ACC_BW-1:0] w_sum;

  // Pixel is zero-extended, weight sign-extended, both to the full product width.
  always_comb begin
    w_prod = '{default: '0};
    for (int i = 0; i < KX; i++) begin
      w_prod[i] = $signed({{W_BW{1'b0}}, i_pix[i*I_F_BW +: I_F_BW]}) *
                  $signed({{(I_F_BW+1){i_w[i*W_BW+W_BW-1]}}, i_w[i*W_BW +: W_BW]});
    end
  end

  // S1: capture products only when a window arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KX; i++) r_prod[i] <= '0;
    end else if (i_en_s1) begin
      for (int i = 0; i < KX; i++) r_prod[i] <= w_prod[i];
    end
  end

  // Row sum with every product sign-extended to the accumulator width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KX; i++) w_sum = w_sum + ACC_BW'(r_prod[i]);
  end

  // S2: register the row partial.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     o_row <= '0;
    else if (i_en_s2) o_row <= w_sum;
  end

endmodule

// File: rtl/conv5x5_mac.sv
// 5x5 convolution MAC: coefficient register file, row MACs, bias add and
// ReLU/shift/saturate output. Four-cycle latency, one window per cycle.
module conv5x5_mac import conv_pkg::*; #(
  parameter int I_F_BW = PIX_BW,
  parameter int W_BW   = WGT_BW,
  parameter int B_BW   = BIAS_BW,
  parameter int ACC_BW = ACC_W,
  parameter int SHIFT  = OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_window_valid,
  input  logic [KN*I_F_BW-1:0]     i_window,
  input  logic                     i_w_we,
  input  logic [4:0]               i_w_addr,
  input  logic [B_BW-1:0]          i_w_data,
  output logic                     o_valid,
  output logic signed [ACC_BW-1:0] o_acc,
  output logic [I_F_BW-1:0]        o_pixel
);

  logic [KN*W_BW-1:0]       r_w;
  logic signed [B_BW-1:0]   r_bias;
  logic                     r_v1;
  logic                     r_v2;
  logic                     r_v3;
  logic signed [ACC_BW-1:0] w_row [KY];
  logic signed [ACC_BW-1:0] w_acc_sum;
  logic signed [ACC_BW-1:0] r_acc;
  logic signed [31:0]       w_acc32;
  logic [I_F_BW-1:0]        w_sat;

  // Coefficient writes; addresses beyond the bias slot are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w    <= '0;
      r_bias <= '0;
    end else if (i_w_we) begin
      if (int'(i_w_addr) < KN)
        r_w[int'(i_w_addr)*W_BW +: W_BW] <= i_w_data[W_BW-1:0];
      else if (int'(i_w_addr) == BIAS_ADDR)
        r_bias <= i_w_data;
    end
  end

  // One row MAC per kernel row; wy=0 is the oldest image row.
  for (genvar gy = 0; gy < KY; gy++) begin : g_row
    mac_row5 #(
      .I_F_BW (I_F_BW),
      .W_BW   (W_BW),
      .ACC_BW (ACC_BW)
    ) u_row (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en_s1 (i_window_valid),
      .i_en_s2 (r_v1),
      .i_pix   (i_window[gy*KX*I_F_BW +: KX*I_F_BW]),
      .i_w     (r_w[gy*KX*W_BW +: KX*W_BW]),
      .o_row   (w_row[gy])
    );
  end

  // Valid pipeline; bubbles shift through as zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      r_v1    <= i_window_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      o_valid <= r_v3;
    end
  end

  // Sum of row partials plus the bias as it stands at S3.
  always_comb begin
    w_acc_sum = ACC_BW'(r_bias);
    for (int i = 0; i < KY; i++) w_acc_sum = w_acc_sum + w_row[i];
  end

  // S3: accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_acc <= '0;
    else if (r_v2) r_acc <= w_acc_sum;
  end

  assign w_acc32 = 32'(r_acc);
  assign w_sat   = I_F_BW'(sat_relu(w_acc32, SHIFT, I_F_BW));

  // S4: outputs hold their last value between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_acc   <= '0;
      o_pixel <= '0;
    end else if (r_v3) begin
      o_acc   <= r_acc;
      o_pixel <= w_sat;
    end
  end

endmodule

// File: doc/conv5x5_mac.md
Name: conv5x5_mac

Overview:
- Pipelined 5x5 convolution engine directly downstream of the 5x5 line-buffer stage in the 28x28 image path.
- Each valid cycle it consumes one 25-pixel window, multiplies it by a runtime-loadable signed 5x5 kernel, adds a signed bias, and emits a raw accumulator plus a ReLU/shift/saturated 8-bit feature pixel.
- Fixed latency of 4 cycles, one result per cycle; no backpressure.

Parameters:
- I_F_BW, 8, unsigned input pixel width.
- W_BW, 8, signed weight width.
- B_BW, 16, signed bias width.
- KX, 5, kernel width.
- KY, 5, kernel height.
- ACC_BW, 24, signed accumulator width; must be >= I_F_BW+W_BW+1+clog2(KX*KY)+1.
- SHIFT, 6, arithmetic right shift applied before output saturation.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_window_valid  in  1  window valid strobe.
- i_window  in  KX*KY*I_F_BW  window; element k=wy*KX+wx at bits [k*I_F_BW +: I_F_BW]; wy=0 is the oldest row, wx=0 is the leftmost column.
- i_w_we  in  1  weight/bias write strobe.
- i_w_addr  in  5  0..KX*KY-1 selects weight k; KX*KY selects bias; larger values are ignored.
- i_w_data  in  B_BW  write data; weights take the low W_BW bits, bias takes all B_BW bits.
- o_valid  out  1  result valid.
- o_acc  out  ACC_BW  signed sum of products plus bias, before ReLU.
- o_pixel  out  I_F_BW  ReLU, then >>SHIFT, then saturate to [0, 2^I_F_BW-1].

Behaviour:
- Reset: all weights, bias, pipeline data and valid flags cleared. o_valid=0, o_acc=0, o_pixel=0. Reset asserted mid-stream flushes in-flight results; none emerge after release.
- Reset state is legal: the all-zero kernel yields o_acc=0 and o_pixel=0.
- Pixels are zero-extended to signed I_F_BW+1 bits. Each product is signed I_F_BW+W_BW+1 bits. All sums are sign-extended to ACC_BW.
- S1 (cycle +1): register 25 products p[k]=pix[k]*w[k] and valid v1.
- S2 (+2): register 5 row partials r[wy]=sum over wx of p[wy*KX+wx], and v2.
- S3 (+3): register acc = sum of r[] + sign-extended bias, and v3.
- S4 (+4): o_acc<=acc; o_pixel<=sat(relu(acc)>>>SHIFT); o_valid<=v3.
- Latency is exactly 4 cycles from i_window_valid to o_valid. Throughput is 1 per cycle; back-to-back windows produce back-to-back outputs.
- When i_window_valid=0:
  - stage data registers hold their values (enable = incoming valid) to save toggling;
  - valid bits shift 0;
  - o_acc and o_pixel hold their last value while o_valid=0.
- Weight write: the register updates on the clock edge where i_w_we=1. A window entering S1 on that same edge uses the OLD weight; windows in the following cycle use the NEW weight. The bias is sampled at S3, so a bias write affects windows whose S3 occurs after the write edge. The host loads coefficients only between frames; mid-frame coherence is not guaranteed beyond these rules.
- Out-of-range i_w_addr: no state change.
- Saturation: negative acc gives o_pixel=0; relu(acc)>>>SHIFT > 2^I_F_BW-1 gives o_pixel=2^I_F_BW-1.
- No overflow of ACC_BW is possible at the default parameters (worst-case |acc| < 2^21).

Decomposition:
- Package conv_pkg:
  - KX, KY, KN=KX*KY constants;
  - bias address constant KN;
  - product/partial/accumulator width localparams;
  - a sat_relu function.
- One sub-module, mac_row5: a registered 5-element dot-product-and-sum row covering S1 and S2 for one wy, instantiated KY times.
- The top holds the weight/bias register file, S3, S4 and the valid pipeline.

Test Plan:
- Reset defaults: all weights 0, window all 255, valid pulse -> o_valid 4 cycles later with o_acc=0, o_pixel=0.
- Identity centre tap: load w[12]=1 (others 0), SHIFT=0 build, window pixel k=k -> o_acc=12, o_pixel=12.
- Box filter with negative bias: all w=1, bias=-100, all pixels 10 -> o_acc=150, o_pixel=150>>6=2; bias=-300 -> o_acc=-50, o_pixel=0.
- Saturation: all w=127, all pixels 255 -> o_acc=809625, o_pixel=255; all w=-128 -> o_acc=-816000, o_pixel=0.
- Streaming/latency: 28 back-to-back windows, then a gap of 3, then 5 more -> o_valid pattern identical to input delayed 4 cycles; each o_acc matches the reference model.
- Write-edge and reset-mid-stream: write w[0]=2 on the same edge as window A, window B next cycle (pix[0]=1, rest 0) -> A gives o_acc=old w[0], B gives 2. Assert reset_n low with 3 results in flight -> o_valid=0, no stray outputs after release.
